output_handler: RTL and testbench

- Transmit-side counterpart of input_handler.
- Takes a 256-bit result, such as the SHA-256 digest collected by the controller, plus the originating command byte.
- Serialises them as a framed, checksummed byte stream into the uart transmitter, one byte per transmit handshake.
- Sits between the top-level controller and uart.tx_byte/transmit, replacing the current echo path.

---
 rtl/output_handler_pkg.sv | 38 +++
 rtl/output_handler.sv | 119 +++++++++++
 tb/tb_output_handler.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/output_handler_pkg.sv
// Shared framing definitions for the uart link: sync byte, field offsets,
// state encodings and the checksum rule used by both frame directions.
package output_handler_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam int         PAYLOAD_BYTES = 32;
  localparam int         DATA_WIDTH    = 8 * PAYLOAD_BYTES;
  localparam int         FRAME_BYTES   = 5 + PAYLOAD_BYTES;

  localparam logic [15:0] PAYLOAD_LEN = 16'(PAYLOAD_BYTES);

  // Byte offsets inside a frame, sized to the 6-bit byte counter.
  localparam logic [5:0] IDX_SYNC    = 6'd0;
  localparam logic [5:0] IDX_CMD     = 6'd1;
  localparam logic [5:0] IDX_LEN_HI  = 6'd2;
  localparam logic [5:0] IDX_LEN_LO  = 6'd3;
  localparam logic [5:0] IDX_PAYLOAD = 6'd4;
  localparam logic [5:0] IDX_CSUM    = 6'(FRAME_BYTES - 1);

  typedef enum logic [7:0] {
    ST_IDLE       = 8'h00,
    ST_LOAD       = 8'h01,
    ST_SEND       = 8'h02,
    ST_WAIT_START = 8'h03,
    ST_WAIT_DONE  = 8'h04,
    ST_DONE       = 8'h05
  } frame_state_e;

  // Every byte after SYNC contributes, except the checksum itself.
  function automatic logic is_summed(input logic [5:0] idx);
    return (idx != IDX_SYNC) && (idx != IDX_CSUM);
  endfunction

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/output_handler.sv
// Serialises a command byte and a 256-bit result into a framed, checksummed
// byte stream, handing one byte at a time to the uart transmitter.
module output_handler
  import output_handler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  send,
  input  logic [7:0]            command,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  is_transmitting,
  output logic                  transmit,
  output logic [7:0]            tx_byte,
  output logic                  busy,
  output logic                  done
);

  frame_state_e          state_q, state_d;
  logic [5:0]            idx_q, idx_d;
  logic [7:0]            csum_q, csum_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      csum_q    <= '0;
      cmd_q     <= '0;
      tx_byte_q <= '0;
      shift_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      cmd_q     <= cmd_d;
      tx_byte_q <= tx_byte_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    cmd_d     = cmd_q;
    tx_byte_d = tx_byte_q;
    shift_d   = shift_q;
    busy_d    = busy_q;
    transmit  = 1'b0;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (send) begin
          cmd_d   = command;
          shift_d = data;
          csum_d  = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // Payload always comes from the top of the shift register.
        case (idx_q)
          IDX_SYNC:   tx_byte_d = SYNC_BYTE;
          IDX_CMD:    tx_byte_d = cmd_q;
          IDX_LEN_HI: tx_byte_d = PAYLOAD_LEN[15:8];
          IDX_LEN_LO: tx_byte_d = PAYLOAD_LEN[7:0];
          IDX_CSUM:   tx_byte_d = csum_q;
          default:    tx_byte_d = shift_q[DATA_WIDTH-1 -: 8];
        endcase
        state_d = ST_SEND;
      end

      ST_SEND: begin
        if (!is_transmitting) begin
          transmit = 1'b1;
          if (is_summed(idx_q)) csum_d = csum_add(csum_q, tx_byte_q);
          state_d = ST_WAIT_START;
        end
      end

      ST_WAIT_START: begin
        if (is_transmitting) state_d = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        if (!is_transmitting) begin
          if (idx_q == IDX_CSUM) begin
            state_d = ST_DONE;
          end else begin
            if (idx_q < IDX_CSUM)     idx_d   = idx_q + 6'd1;
            if (idx_q >= IDX_PAYLOAD) shift_d = shift_q << 8;
            state_d = ST_LOAD;
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_byte = tx_byte_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_output_handler.sv
// Randomised frame-level bench for output_handler with a behavioural uart and
// a frame builder computed straight from the framing rules.
module tb_output_handler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         send = 1'b0;
  logic [7:0]   command = 8'h00;
  logic [255:0] data = '0;
  logic         is_transmitting = 1'b0;
  logic         transmit;
  logic [7:0]   tx_byte;
  logic         busy;
  logic         done;

  output_handler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .send            (send),
    .command         (command),
    .data            (data),
    .is_transmitting (is_transmitting),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: captures every transmitted byte and protocol violations.
  logic [7:0] rx_bytes[$];
  int         rx_cyc[$];
  int         done_cnt = 0;
  int         busy_gap = 0;
  int         dbl_tx = 0;
  int         tx_while_busy = 0;
  bit         prev_tx = 1'b0;
  bit         in_frame = 1'b0;

  always @(negedge clk) begin
    if (transmit) begin
      rx_bytes.push_back(tx_byte);
      rx_cyc.push_back(cyc);
      if (is_transmitting) tx_while_busy++;
    end
    if (transmit && prev_tx) dbl_tx++;
    prev_tx = transmit;
    if (done) done_cnt++;
    if (in_frame && !busy) busy_gap++;
  end

  // Uart model: raises is_transmitting after each handshake for a few cycles.
  int uart_idx = 0;
  int hold_abs = -1;
  initial begin
    forever begin
      @(negedge clk);
      if (transmit) begin
        int h;
        h = (uart_idx == hold_abs) ? 53 : 3;
        uart_idx++;
        @(posedge clk);
        #1 is_transmitting = 1'b1;
        repeat (h) @(posedge clk);
        #1 is_transmitting = 1'b0;
      end
    end
  end

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic run_frame(input string name, input logic [7:0] cmd, input logic [255:0] d,
                           input int hold_off, input int busy_at, input int reset_at);
    int base, dbase, gbase, c0;
    bit finished, injected;
    logic [7:0] exp_q[$];
    logic [7:0] sum;

    base  = rx_bytes.size();
    dbase = done_cnt;
    gbase = busy_gap;
    hold_abs = (hold_off >= 0) ? uart_idx + hold_off : -1;
    finished = 0;
    injected = 0;

    @(posedge clk);
    #1;
    command = cmd;
    data    = d;
    send    = 1'b1;
    c0      = cyc;
    @(posedge clk);
    #1;
    send     = 1'b0;
    in_frame = 1'b1;
    command  = 8'($urandom);
    data     = rand256();

    for (int k = 0; k < 4000 && !finished; k++) begin
      @(posedge clk);
      #2;
      if (done_cnt > dbase) finished = 1;
      if (busy_at >= 0 && !injected && rx_bytes.size() - base >= busy_at) begin
        injected = 1;
        send    = 1'b1;
        command = ~cmd;
        data    = ~d;
        @(posedge clk);
        #1 send = 1'b0;
      end
      if (reset_at >= 0 && rx_bytes.size() - base == reset_at && transmit) begin
        rst_n = 1'b0;
        #1;
        chk({name, ".rst_transmit"}, 64'(transmit), 64'd0);
        chk({name, ".rst_busy"},     64'(busy),     64'd0);
        chk({name, ".rst_done"},     64'(done),     64'd0);
        chk({name, ".rst_tx_byte"},  64'(tx_byte),  64'd0);
        in_frame = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        $display("frame %s aborted by reset after %0d bytes", name, rx_bytes.size() - base);
        return;
      end
    end
    in_frame = 1'b0;
    chk({name, ".timeout"}, 64'(finished), 64'd1);

    // Reference frame built from the framing rules.
    exp_q.push_back(8'hA5);
    exp_q.push_back(cmd);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h20);
    for (int i = 31; i >= 0; i--) exp_q.push_back(d[i*8 +: 8]);
    sum = 8'h00;
    for (int i = 1; i < exp_q.size(); i++) sum = sum + exp_q[i];
    exp_q.push_back(sum);

    chk({name, ".len"}, 64'(rx_bytes.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < rx_bytes.size(); i++)
      chk($sformatf("%s.byte%0d", name, i), 64'(rx_bytes[base + i]), 64'(exp_q[i]));
    chk({name, ".done_pulses"}, 64'(done_cnt - dbase), 64'd1);
    chk({name, ".busy_gap"}, 64'(busy_gap - gbase), 64'd0);
    chk({name, ".busy_after"}, 64'(busy), 64'd0);
    if (rx_cyc.size() > base)
      chk({name, ".latency"}, 64'(rx_cyc[base] - c0), 64'd2);
    $display("frame %s cmd=%02h bytes=%0d csum=%02h", name, cmd, rx_bytes.size() - base, sum);
  endtask

  task automatic wait_uart_idle();
    int k;
    k = 0;
    while (is_transmitting && k < 200) begin
      @(posedge clk);
      k++;
    end
    chk("uart_idle", 64'(is_transmitting), 64'd0);
  endtask

  initial begin
    logic [255:0] abc;
    abc = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.transmit", 64'(transmit), 64'd0);
    chk("reset.tx_byte",  64'(tx_byte),  64'd0);
    chk("reset.busy",     64'(busy),     64'd0);
    chk("reset.done",     64'(done),     64'd0);
    rst_n = 1'b1;

    run_frame("zero", 8'h02, '0, -1, -1, -1);
    run_frame("ones", 8'h02, '1, -1, -1, -1);
    run_frame("abc",  8'h01, abc, -1, -1, -1);
    run_frame("backpressure", 8'($urandom), rand256(), 10, -1, -1);
    run_frame("send_busy", 8'($urandom), rand256(), -1, 5, -1);
    run_frame("after_busy", 8'($urandom), rand256(), -1, -1, -1);
    run_frame("reset_mid", 8'($urandom), rand256(), -1, -1, 24);
    wait_uart_idle();
    run_frame("after_reset", 8'($urandom), rand256(), -1, -1, -1);
    for (int r = 0; r < 3; r++)
      run_frame($sformatf("rand%0d", r), 8'($urandom), rand256(), -1, -1, -1);

    chk("double_transmit", 64'(dbl_tx), 64'd0);
    chk("transmit_while_uart_busy", 64'(tx_while_busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
